demux4_deserializer: RTL

Registered 1-to-4 demultiplexer and deserializer; the receive-side counterpart of the 4-to-1 bit selector used in the universal shift register datapath.
- Each accepted serial bit is steered by a 2-bit lane select into one of four independent lane shift registers.
- When a lane has collected WIDTH bits, it publishes a parallel word and pulses a per-lane valid.
- Sits between a serial source (shift register serial-out or mux output) and parallel consumers.

---
 rtl/demux4_deserializer_pkg.sv | 28 ++
 rtl/demux4_deserializer_lane.sv | 74 +++++++
 rtl/demux4_deserializer.sv | 46 ++++
 3 files changed

// File: rtl/demux4_deserializer_pkg.sv
// Shared definitions for the 1-to-4 serial demultiplexer / deserializer.
//   NUM_LANES : number of output lanes
//   LANE0..3  : lane select encodings presented on sel
//   LANE_SEL  : the same encodings indexed by lane number
//   clog2     : bit-counter width helper (minimum result 1)
package demux4_deserializer_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] LANE0 = 2'b00;
  localparam logic [1:0] LANE1 = 2'b01;
  localparam logic [1:0] LANE2 = 2'b10;
  localparam logic [1:0] LANE3 = 2'b11;

  localparam logic [1:0] LANE_SEL [NUM_LANES] = '{LANE0, LANE1, LANE2, LANE3};

  // Smallest r with 2**r >= value. Never returns 0, so a counter declared
  // with this width is always at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/demux4_deserializer_lane.sv
// One deserializer lane: collects WIDTH serial bits MSB first and publishes
// them as a parallel word with a one-cycle valid pulse.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   D            : serial data bit
//   shift_en     : D belongs to this lane this cycle
//   clr          : synchronous clear of staging register and bit counter
//   word         : last completed word (held until the next completion)
//   word_valid   : one-cycle pulse when word updates
//   busy         : a partial word is being collected
module lane_deserializer
  import demux4_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             D,
  input  logic             shift_en,
  input  logic             clr,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    // clr wins over shift_en; the published word is deliberately untouched.
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[WIDTH-2:0], D};
      if (cnt_q == LAST) begin
        // The staging register keeps its shifted value; only the counter
        // decides where the next word starts, so no bubble is needed.
        cnt_d   = '0;
        word_d  = {shift_q[WIDTH-2:0], D};
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: rtl/demux4_deserializer.sv
// Registered 1-to-4 demultiplexer and deserializer. Each accepted serial bit
// is steered by sel into one of four independent lane deserializers.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   D            : serial data bit
//   sel          : lane select (00 lane0 .. 11 lane3)
//   en           : D is valid this cycle
//   clr          : synchronous clear of all lane staging state (Q kept)
//   Q            : parallel words, lane k at Q[k*WIDTH +: WIDTH]
//   valid        : per-lane one-cycle pulse when its Q field updates
//   busy         : per-lane partial-word indicator
module demux4_deserializer
  import demux4_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       D,
  input  logic [1:0]                 sel,
  input  logic                       en,
  input  logic                       clr,
  output logic [NUM_LANES*WIDTH-1:0] Q,
  output logic [NUM_LANES-1:0]       valid,
  output logic [NUM_LANES-1:0]       busy
);

  logic [NUM_LANES-1:0] shift_en;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign shift_en[k] = en & (sel == LANE_SEL[k]);

    lane_deserializer #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .D          (D),
      .shift_en   (shift_en[k]),
      .clr        (clr),
      .word       (Q[k*WIDTH +: WIDTH]),
      .word_valid (valid[k]),
      .busy       (busy[k])
    );
  end

endmodule
